log_fir_tap_scheduler: RTL and testbench

Folded sequencer for the log-domain FIR tap datapath. It shares a bank of `LANES` log-domain multipliers across `ORD` filter taps by stepping a group address over the sample and weight memories. Each cycle it sums the `LANES` linear tap products into a wide accumulator and, after `ORD/LANES` groups, emits one saturated filter output. It sits between the log-domain sample/weight stores and the error/weight-update stage of the adaptive filter.

---
 rtl/log_fir_tap_scheduler_pkg.sv | 32 +++
 rtl/log_fir_tap_scheduler_if.sv | 31 +++
 rtl/log_fir_lane_sum.sv | 19 +
 rtl/log_fir_tap_scheduler.sv | 109 ++++++++++
 tb/tb_log_fir_tap_scheduler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/log_fir_tap_scheduler_pkg.sv
// Shared constants for the folded log-domain FIR tap schedulers.
// FSM encoding, group/accumulator sizing and saturation limits.
package log_fir_tap_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int groups_of(input int ord, input int lanes);
    return ord / lanes;
  endfunction

  function automatic int acc_w_of(input int width, input int ord);
    return width + $clog2(ord) + 1;
  endfunction

  function automatic int addr_w_of(input int groups);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

  function automatic int sat_hi(input int width);
    return (2 ** (width - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int width);
    return -(2 ** (width - 1));
  endfunction

endpackage

// File: rtl/log_fir_tap_scheduler_if.sv
// Scheduler bus: start/ready control, memory read strobe and group address,
// lane products in, saturated filter output with valid pulse.
interface log_fir_tap_scheduler_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 8,
  parameter int ORD   = 64
);
  import log_fir_tap_scheduler_pkg::*;

  localparam int AW = addr_w_of(groups_of(ORD, LANES));

  logic                     start;
  logic                     ready;
  logic                     busy;
  logic                     mem_rd_en;
  logic [AW-1:0]            grp_addr;
  logic [LANES*WIDTH-1:0]   tap_in_packed;
  logic [WIDTH-1:0]         y_out;
  logic                     y_valid;

  modport master (
    output start, tap_in_packed,
    input  ready, busy, mem_rd_en, grp_addr, y_out, y_valid
  );

  modport slave (
    input  start, tap_in_packed,
    output ready, busy, mem_rd_en, grp_addr, y_out, y_valid
  );

endinterface

// File: rtl/log_fir_lane_sum.sv
// Combinational signed adder tree over LANES products of WIDTH bits.
// Ports: lanes (packed, lane k at [WIDTH*k +: WIDTH]), sum (full precision).
module log_fir_lane_sum #(
  parameter int WIDTH = 16,
  parameter int LANES = 8
) (
  input  logic [LANES*WIDTH-1:0]                  lanes,
  output logic signed [WIDTH+$clog2(LANES)-1:0]   sum
);
  localparam int SUM_W = WIDTH + $clog2(LANES);

  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = sum + SUM_W'(signed'(lanes[WIDTH*k +: WIDTH]));
    end
  end

endmodule

// File: rtl/log_fir_tap_scheduler.sv
// Folded FIR tap sequencer: walks GROUPS groups, accumulates lane sums and
// emits one saturated output. Ports: clk, reset (sync, high), bus (slave).
module log_fir_tap_scheduler
  import log_fir_tap_scheduler_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int ORD       = 64,
  parameter int LANES     = 8,
  parameter int LOG_WIDTH = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  log_fir_tap_scheduler_if.slave  bus
);
  localparam int GROUPS = groups_of(ORD, LANES);
  localparam int ACC_W  = acc_w_of(WIDTH, ORD);
  localparam int AW     = addr_w_of(GROUPS);
  localparam int SUM_W  = WIDTH + $clog2(LANES);

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_hi(WIDTH));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_lo(WIDTH));

  if (ORD % LANES != 0) begin : g_bad_ord
    $error("ORD must be a multiple of LANES");
  end
  if (QP >= WIDTH || LOG_WIDTH < 2) begin : g_bad_fmt
    $error("bad QP/LOG_WIDTH");
  end

  state_t                   state;
  logic                     dv;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [SUM_W-1:0]  lane_sum;
  logic [WIDTH-1:0]         y_sat;

  log_fir_lane_sum #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_sum (
    .lanes (bus.tap_in_packed),
    .sum   (lane_sum)
  );

  // Output is registered from the post-accumulate value so the last
  // group, arriving during DRAIN, is included in the DONE-cycle output.
  always_comb begin
    acc_nxt = acc;
    if (dv) acc_nxt = acc + ACC_W'(lane_sum);
  end

  always_comb begin
    y_sat = acc_nxt[WIDTH-1:0];
    if (acc_nxt > ACC_MAX)      y_sat = {1'b0, {(WIDTH-1){1'b1}}};
    else if (acc_nxt < ACC_MIN) y_sat = {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      dv            <= 1'b0;
      acc           <= '0;
      bus.ready     <= 1'b1;
      bus.busy      <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.grp_addr  <= '0;
      bus.y_out     <= '0;
      bus.y_valid   <= 1'b0;
    end else begin
      dv          <= bus.mem_rd_en;
      acc         <= acc_nxt;
      bus.y_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state         <= S_RUN;
            acc           <= '0;
            bus.ready     <= 1'b0;
            bus.busy      <= 1'b1;
            bus.mem_rd_en <= 1'b1;
            bus.grp_addr  <= '0;
          end
        end
        S_RUN: begin
          if (bus.grp_addr == AW'(GROUPS - 1)) begin
            state         <= S_DRAIN;
            bus.mem_rd_en <= 1'b0;
            bus.grp_addr  <= '0;
          end else begin
            bus.grp_addr  <= bus.grp_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          state       <= S_DONE;
          bus.y_valid <= 1'b1;
          bus.y_out   <= y_sat;
        end
        S_DONE: begin
          state     <= S_IDLE;
          bus.busy  <= 1'b0;
          bus.ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_fir_tap_scheduler.sv
// Directed bench for log_fir_tap_scheduler with a one-cycle-latency
// memory/multiplier model driven from the DUT's read strobe.
module tb_log_fir_tap_scheduler;

  localparam int WIDTH = 16;
  localparam int LANES = 8;
  localparam int ORD   = 64;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   mode;
  logic signed [WIDTH-1:0] val;

  log_fir_tap_scheduler_if #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .ORD   (ORD)
  ) bus ();

  log_fir_tap_scheduler #(
    .WIDTH     (WIDTH),
    .QP        (12),
    .ORD       (ORD),
    .LANES     (LANES),
    .LOG_WIDTH (17)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] lane_val(
    input int m, input logic signed [WIDTH-1:0] v,
    input int g, input int k);
    if (m == 1) return WIDTH'(g);
    if (m == 2) return (k % 2 == 1) ? -v : v;
    return v;
  endfunction

  // Memory + multiplier model: products appear the cycle after the strobe.
  // Junk is driven otherwise so stray accumulation shows up.
  always @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (bus.mem_rd_en)
        bus.tap_in_packed[WIDTH*k +: WIDTH] <=
          lane_val(mode, val, int'(bus.grp_addr), k);
      else
        bus.tap_in_packed[WIDTH*k +: WIDTH] <= 16'sd77;
    end
  end

  task automatic run_one(input int m, input logic signed [WIDTH-1:0] v,
                         input logic [WIDTH-1:0] exp, input string name);
    mode = m;
    val  = v;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k <= 8) begin
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.grp_addr !== 3'(k - 1)) begin
          errors++;
          $display("FAIL %s rd k=%0d: got en=%b addr=%0d want en=1 addr=%0d",
                   name, k, bus.mem_rd_en, bus.grp_addr, k - 1);
        end
      end
      if (k == 9) begin
        checks++;
        if (bus.mem_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL %s drain_rd: got %b want 0", name, bus.mem_rd_en);
        end
      end
      checks++;
      if (bus.y_valid !== (k == 10)) begin
        errors++;
        $display("FAIL %s y_valid k=%0d: got %b want %b",
                 name, k, bus.y_valid, (k == 10));
      end
      if (k >= 10) begin
        checks++;
        if (bus.y_out !== exp) begin
          errors++;
          $display("FAIL %s y_out k=%0d: got %h want %h",
                   name, k, bus.y_out, exp);
        end
      end
      if (k == 11) begin
        checks++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL %s ready: got r=%b b=%b want r=1 b=0",
                   name, bus.ready, bus.busy);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    mode      = 0;
    val       = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0 ||
        bus.grp_addr !== '0 || bus.y_out !== '0 || bus.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: got r=%b b=%b en=%b a=%0d y=%h v=%b want 1 0 0 0 0000 0",
               bus.ready, bus.busy, bus.mem_rd_en, bus.grp_addr,
               bus.y_out, bus.y_valid);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones();
    run_one(0, 16'sd1, 16'd64, "ones");
  endtask

  task automatic test_ramp();
    run_one(1, 16'sd0, 16'd224, "ramp");
  endtask

  task automatic test_sat_pos();
    run_one(0, 16'sh7FFF, 16'h7FFF, "sat_pos");
  endtask

  task automatic test_sat_neg();
    run_one(0, -16'sd32768, 16'h8000, "sat_neg");
  endtask

  task automatic test_alternate();
    run_one(2, 16'sd100, 16'h0000, "alt");
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    mode = 0;
    val  = 16'sd1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      bus.start = (k == 3 || k == 10 || k == 11);
      if (k == 11) val = 16'sd3;
      if (bus.y_valid === 1'b1) pulses++;
      checks++;
      if (bus.y_valid !== (k == 10 || k == 21)) begin
        errors++;
        $display("FAIL b2b y_valid k=%0d: got %b want %b",
                 k, bus.y_valid, (k == 10 || k == 21));
      end
      if (k == 3) begin
        checks++;
        if (bus.ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b busy_ready: got %b want 0", bus.ready);
        end
      end
      if (k == 10) begin
        checks++;
        if (bus.y_out !== 16'd64) begin
          errors++;
          $display("FAIL b2b first: got %h want %h", bus.y_out, 16'd64);
        end
      end
      if (k == 11) begin
        checks++;
        if (bus.ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b ready: got %b want 1", bus.ready);
        end
      end
      if (k == 21) begin
        checks++;
        if (bus.y_out !== 16'd192) begin
          errors++;
          $display("FAIL b2b second: got %h want %h", bus.y_out, 16'd192);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b pulses: got %0d want 2", pulses);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    int pulses;
    pulses = 0;
    mode = 0;
    val  = 16'sd5;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.mem_rd_en !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got en=%b r=%b b=%b want 0 1 0",
               bus.mem_rd_en, bus.ready, bus.busy);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.y_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_novalid: got %0d pulses want 0", pulses);
    end
    run_one(0, 16'sd2, 16'd128, "after_abort");
  endtask

  task automatic test_reset_start();
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_start: got r=%b b=%b en=%b want 1 0 0",
               bus.ready, bus.busy, bus.mem_rd_en);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_hold: got en=%b b=%b want 0 0",
               bus.mem_rd_en, bus.busy);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    mode      = 0;
    val       = '0;
    test_reset();
    test_ones();
    test_ramp();
    test_sat_pos();
    test_sat_neg();
    test_alternate();
    test_back_to_back();
    test_abort();
    test_reset_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
